// File: rtl/ysyx_22050019_axi_rd_slave.sv
// Memory-side read responder: one outstanding AR, programmable wait, one 64-bit R beat.
// A side write port preloads or patches the word array in any state.
module ysyx_22050019_axi_rd_slave #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned           MEM_WORDS  = 1024,
   parameter int unsigned           LATENCY    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ar_valid_i,
   output logic                      ar_ready_o,
   input  logic [ADDR_WIDTH-1:0]     ar_addr_i,
   output logic                      r_valid_o,
   input  logic                      r_ready_i,
   output logic [1:0]                r_resp_o,
   output logic [DATA_WIDTH-1:0]     r_data_o,
   input  logic                      wr_en_i,
   input  logic [$clog2(MEM_WORDS):0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0]     wr_data_i
);

   localparam int unsigned           IdxW      = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] MemWordsA = ADDR_WIDTH'(MEM_WORDS);
   localparam logic [3:0]            Lat       = 4'(LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   ar_ready_q, ar_ready_d;
   logic                   r_valid_q, r_valid_d;
   logic [1:0]             r_resp_q, r_resp_d;
   logic [DATA_WIDTH-1:0]  r_data_q, r_data_d;
   logic [DATA_WIDTH-1:0]  mem [MEM_WORDS];
   logic [ADDR_WIDTH-1:0]  idx;
   logic                   in_range;

   // Wrapping subtract: addresses below the base yield a huge idx, but are also caught explicitly.
   assign idx      = (addr_q - BASE_ADDR) >> 3;
   assign in_range = (addr_q >= BASE_ADDR) && (idx < MemWordsA);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      r_valid_d = r_valid_q;
      r_resp_d  = r_resp_q;
      r_data_d  = r_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (ar_valid_i && ar_ready_q) begin
               addr_d  = ar_addr_i;
               cnt_d   = Lat;
               state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_RESP;
         end
         S_RESP: begin
            // First cycle in S_RESP captures the beat; later cycles hold it until accepted.
            if (!r_valid_q) begin
               r_valid_d = 1'b1;
               r_resp_d  = in_range ? 2'b00 : 2'b11;
               r_data_d  = in_range ? mem[idx[IdxW-1:0]] : '0;
            end else if (r_ready_i) begin
               r_valid_d = 1'b0;
               r_data_d  = '0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      ar_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_resp_q   <= 2'b00;
         r_data_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         ar_ready_q <= ar_ready_d;
         r_valid_q  <= r_valid_d;
         r_resp_q   <= r_resp_d;
         r_data_q   <= r_data_d;
      end
   end

   // Array is not reset; the MSB of wr_addr_i marks an out-of-range write, which is dropped.
   always_ff @(posedge clk) begin
      if (wr_en_i && !wr_addr_i[IdxW]) mem[wr_addr_i[IdxW-1:0]] <= wr_data_i;
   end

   assign ar_ready_o = ar_ready_q;
   assign r_valid_o  = r_valid_q;
   assign r_resp_o   = r_resp_q;
   assign r_data_o   = r_data_q;

endmodule
